bit_serial_alu_seq: RTL and testbench



---
 rtl/bit_serial_alu_seq.sv | 149 ++++++++++++++
 tb/tb_bit_serial_alu_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU: one 1-bit slice steps across the operands LSB first, one bit per clock.
// SLT is resolved from the MSB set bit in a final step; results are held until the next done.
module bit_serial_alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       alu_ctrl,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StFinish = 2'd2;

    logic [1:0]       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, sr_q, result_q;
    logic             carry_q, a_inv_q, b_inv_q, valid_q;
    logic [1:0]       op_q;
    logic             ov_raw_q, set_q, done_q, zero_q, overflow_q;

    logic             dec_a_inv, dec_b_inv, dec_valid;
    logic [1:0]       dec_op;
    logic             ai, bi, sum, cout, bit_res, ov_now;
    logic [WIDTH-1:0] fin_result;

    always_comb begin
        dec_a_inv = 1'b0;
        dec_b_inv = 1'b0;
        dec_op    = 2'b00;
        dec_valid = 1'b1;
        case (alu_ctrl)
            4'b0000: dec_op = 2'b00;
            4'b0001: dec_op = 2'b01;
            4'b0010: dec_op = 2'b10;
            4'b0110: begin dec_b_inv = 1'b1; dec_op = 2'b10; end
            4'b0111: begin dec_b_inv = 1'b1; dec_op = 2'b11; end
            4'b1100: begin dec_a_inv = 1'b1; dec_b_inv = 1'b1; dec_op = 2'b00; end
            4'b1101: begin dec_a_inv = 1'b1; dec_b_inv = 1'b1; dec_op = 2'b01; end
            default: dec_valid = 1'b0;
        endcase
    end

    // 1-bit slice; operands are shifted right so bit 0 is always the current bit.
    always_comb begin
        ai      = a_q[0] ^ a_inv_q;
        bi      = b_q[0] ^ b_inv_q;
        sum     = ai ^ bi ^ carry_q;
        cout    = (ai & bi) | (ai & carry_q) | (bi & carry_q);
        ov_now  = carry_q ^ cout;
        bit_res = 1'b0;
        case (op_q)
            2'b00:   bit_res = ai & bi;
            2'b01:   bit_res = ai | bi;
            2'b10:   bit_res = sum;
            default: bit_res = 1'b0;
        endcase
    end

    always_comb begin
        fin_result = '0;
        if (valid_q) begin
            if (op_q == 2'b11) begin
                fin_result = {{(WIDTH-1){1'b0}}, set_q};
            end else begin
                fin_result = sr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sr_q       <= '0;
            carry_q    <= 1'b0;
            a_inv_q    <= 1'b0;
            b_inv_q    <= 1'b0;
            op_q       <= 2'b00;
            valid_q    <= 1'b0;
            ov_raw_q   <= 1'b0;
            set_q      <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= src_a;
                        b_q     <= src_b;
                        a_inv_q <= dec_a_inv;
                        b_inv_q <= dec_b_inv;
                        op_q    <= dec_op;
                        valid_q <= dec_valid;
                        carry_q <= dec_b_inv;
                        cnt_q   <= '0;
                        sr_q    <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    sr_q    <= {bit_res, sr_q[WIDTH-1:1]};
                    carry_q <= cout;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    if (cnt_q == LastBit) begin
                        ov_raw_q <= ov_now;
                        set_q    <= sum ^ ov_now;
                        state_q  <= StFinish;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StFinish: begin
                    result_q   <= fin_result;
                    zero_q     <= (fin_result == '0);
                    overflow_q <= valid_q && (op_q == 2'b10) && ov_raw_q;
                    done_q     <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready    = (state_q == StIdle);
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Self-checking bench for bit_serial_alu_seq: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_bit_serial_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [3:0]  alu_ctrl;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    int n_checks = 0;
    int n_fails  = 0;

    bit_serial_alu_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_a    (src_a),
        .src_b    (src_b),
        .alu_ctrl (alu_ctrl),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {overflow, result} from plain arithmetic on the operands.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
        logic [31:0] r;
        logic        ov;
        r  = '0;
        ov = 1'b0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                r  = a + b;
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0110: begin
                r  = a - b;
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
            4'b1101: r = ~(a & b);
            default: r = '0;
        endcase
        return {ov, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] c);
        logic [32:0] m;
        m = model(a, b, c);
        check({tag, "_result"}, result, m[31:0]);
        check({tag, "_zero"}, 32'(zero), 32'(m[31:0] == 32'd0));
        check({tag, "_ovf"}, 32'(overflow), 32'(m[32]));
    endtask

    // Issues one op, scrambles inputs after accept, optionally pokes start during RUN.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c, input bit noisy);
        logic [31:0] prev_res;
        int lat;
        @(negedge clk);
        src_a    = a;
        src_b    = b;
        alu_ctrl = c;
        start    = 1'b1;
        check({tag, "_ready_pre"}, 32'(ready), 32'd1);
        prev_res = result;
        @(posedge clk);
        #1;
        start    = 1'b0;
        src_a    = $urandom;
        src_b    = $urandom;
        alu_ctrl = 4'($urandom);
        check({tag, "_ready_busy"}, 32'(ready), 32'd0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            start = (noisy && lat < 32) ? lat[0] : 1'b0;
            if (lat == 16) check({tag, "_held"}, result, prev_res);
        end while (!done && lat < 60);
        start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'd33);
        check_result(tag, a, b, c);
        @(posedge clk);
        #1;
        check({tag, "_done_fall"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [3:0]  codes [8];
        logic [31:0] ra, rb;
        logic [3:0]  rc;
        int k;

        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b1111};
        rst_n    = 1'b0;
        start    = 1'b0;
        src_a    = '0;
        src_b    = '0;
        alu_ctrl = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Leave a nonzero result so the mid-run reset is observable.
        run_op("pre", 32'h7FFF_FFFF, 32'd1, 4'b0010, 1'b0);

        @(negedge clk);
        src_a = 32'd100; src_b = 32'd200; alu_ctrl = 4'b0010; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add34", 32'd3, 32'd4, 4'b0010, 1'b0);
        run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 1'b0);
        run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 1'b0);
        run_op("sub_eq", 32'd5, 32'd5, 4'b0110, 1'b0);
        run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 4'b0110, 1'b0);
        run_op("slt_neg", 32'hFFFF_FFFF, 32'h0000_0001, 4'b0111, 1'b0);
        run_op("slt_ovf", 32'h8000_0000, 32'h0000_0001, 4'b0111, 1'b0);
        run_op("slt_big", 32'h7FFF_FFFF, 32'h8000_0000, 4'b0111, 1'b0);
        run_op("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 1'b0);
        run_op("or", 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0001, 1'b0);
        run_op("nor", 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b1100, 1'b0);
        run_op("nand", 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b1101, 1'b0);
        run_op("unsup", 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b1111, 1'b0);
        run_op("noisy", 32'h1234_5678, 32'h1111_1111, 4'b0110, 1'b1);

        // Back-to-back: start held through the done cycle.
        @(negedge clk);
        src_a = 32'h0000_00FF; src_b = 32'h0000_0F0F; alu_ctrl = 4'b0001; start = 1'b1;
        @(posedge clk);
        #1;
        src_a = 32'h4000_0000; src_b = 32'h4000_0000; alu_ctrl = 4'b0010;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!done && k < 60);
        check("b2b_lat1", 32'(k), 32'd33);
        check_result("b2b_first", 32'h0000_00FF, 32'h0000_0F0F, 4'b0001);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) begin
                start = 1'b0;
                check("b2b_accept", 32'(ready), 32'd0);
            end
        end while (!done && k < 80);
        check("b2b_gap", 32'(k), 32'd34);
        check_result("b2b_second", 32'h4000_0000, 32'h4000_0000, 4'b0010);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = codes[$urandom_range(0, 7)];
            if (i % 6 == 5) rb = ra;
            run_op("rand", ra, rb, rc, (i % 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
